// File: rtl/mc_sequencer_if.sv
// Controlpath/datapath side of the multi-cycle sequencer: ungated strobes in,
// gated strobes, status and performance counters out.
interface mc_sequencer_if #(
    parameter int unsigned OPCODE_W = 6,
    parameter int unsigned CNT_W    = 32
);
    logic [OPCODE_W-1:0] opcode;
    logic                upd_pc_in;
    logic                wr_reg_in;
    logic                wr_mem_in;
    logic                rd_mem_in;
    logic                mem_ready;
    logic                step_mode;
    logic                step_req;
    logic                resume;

    logic                upd_pc;
    logic                wr_reg;
    logic                wr_mem;
    logic [2:0]          state;
    logic                halted;
    logic                bus_err;
    logic [CNT_W-1:0]    instr_count;
    logic [CNT_W-1:0]    cycle_count;

    modport master (
        output opcode, upd_pc_in, wr_reg_in, wr_mem_in, rd_mem_in,
               mem_ready, step_mode, step_req, resume,
        input  upd_pc, wr_reg, wr_mem, state, halted, bus_err,
               instr_count, cycle_count
    );

    modport slave (
        input  opcode, upd_pc_in, wr_reg_in, wr_mem_in, rd_mem_in,
               mem_ready, step_mode, step_req, resume,
        output upd_pc, wr_reg, wr_mem, state, halted, bus_err,
               instr_count, cycle_count
    );
endinterface

// File: rtl/mc_sequencer.sv
// Multi-cycle instruction sequencer: gates datapath strobes to the commit cycle,
// adds memory wait states with timeout, single-step, halt/resume and perf counters.
module mc_sequencer #(
    parameter int unsigned          OPCODE_W    = 6,
    parameter logic [OPCODE_W-1:0]  HALT_OPCODE = OPCODE_W'(6'b100100),
    parameter bit                   HALT_ADV_PC = 1'b0,
    parameter int unsigned          WAIT_MAX    = 8,
    parameter int unsigned          CNT_W       = 32
) (
    input  logic         clk,
    input  logic         reset,
    mc_sequencer_if.slave bus
);
    localparam int unsigned WAIT_W = 8;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEMWAIT = 3'd3,
        S_PAUSE   = 3'd4,
        S_HALT    = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    state_t             w_after_commit;
    logic [WAIT_W-1:0]  r_wait;
    logic [WAIT_W-1:0]  w_wait_nxt;
    logic               w_timeout;
    logic               w_commit;
    logic               w_mem_op;
    logic               w_is_halt;
    logic               w_upd_pc;
    logic               w_wr_reg;
    logic               w_wr_mem;
    logic               r_halted;
    logic               r_bus_err;
    logic [CNT_W-1:0]   r_instr_count;
    logic [CNT_W-1:0]   r_cycle_count;

    assign w_mem_op  = bus.rd_mem_in | bus.wr_mem_in;
    assign w_is_halt = (bus.opcode == HALT_OPCODE);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and wait-counter logic
    always_comb begin
        w_state_nxt    = S_FETCH;
        w_wait_nxt     = r_wait;
        w_timeout      = 1'b0;
        w_after_commit = w_is_halt     ? S_HALT  :
                         bus.step_mode ? S_PAUSE : S_FETCH;
        case (r_state)
            S_FETCH:   w_state_nxt = S_DECODE;
            S_DECODE:  w_state_nxt = S_EXECUTE;
            S_EXECUTE: begin
                if (w_commit) begin
                    w_state_nxt = w_after_commit;
                end else begin
                    w_state_nxt = S_MEMWAIT;
                    w_wait_nxt  = WAIT_W'(1);
                end
            end
            S_MEMWAIT: begin
                if (w_commit) begin
                    w_state_nxt = w_after_commit;
                end else if (r_wait == WAIT_W'(WAIT_MAX)) begin
                    w_state_nxt = S_HALT;
                    w_timeout   = 1'b1;
                end else begin
                    w_state_nxt = S_MEMWAIT;
                    w_wait_nxt  = r_wait + WAIT_W'(1);
                end
            end
            S_PAUSE:   w_state_nxt = (bus.step_req || !bus.step_mode) ? S_FETCH : S_PAUSE;
            S_HALT:    w_state_nxt = bus.resume ? S_FETCH : S_HALT;
            default:   w_state_nxt = S_FETCH;
        endcase
    end

    // Commit detection and gated strobes (Mealy, same cycle)
    always_comb begin
        w_commit = 1'b0;
        w_upd_pc = 1'b0;
        w_wr_reg = 1'b0;
        w_wr_mem = 1'b0;
        case (r_state)
            S_EXECUTE: w_commit = !w_mem_op || bus.mem_ready;
            S_MEMWAIT: w_commit = bus.mem_ready;
            default:   w_commit = 1'b0;
        endcase
        if (w_commit && !reset) begin
            w_upd_pc = bus.upd_pc_in & (HALT_ADV_PC | !w_is_halt);
            w_wr_reg = bus.wr_reg_in;
            w_wr_mem = bus.wr_mem_in;
        end
    end

    // Wait counter, status flags and performance counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait        <= '0;
            r_halted      <= 1'b0;
            r_bus_err     <= 1'b0;
            r_instr_count <= '0;
            r_cycle_count <= '0;
        end else begin
            r_wait   <= w_wait_nxt;
            r_halted <= (w_state_nxt == S_HALT);
            if (w_timeout) begin
                r_bus_err <= 1'b1;
            end else if (r_state == S_HALT && bus.resume) begin
                r_bus_err <= 1'b0;
            end
            if (w_commit) begin
                r_instr_count <= r_instr_count + CNT_W'(1);
            end
            if (r_state != S_HALT) begin
                r_cycle_count <= r_cycle_count + CNT_W'(1);
            end
        end
    end

    assign bus.upd_pc      = w_upd_pc;
    assign bus.wr_reg      = w_wr_reg;
    assign bus.wr_mem      = w_wr_mem;
    assign bus.state       = r_state;
    assign bus.halted      = r_halted;
    assign bus.bus_err     = r_bus_err;
    assign bus.instr_count = r_instr_count;
    assign bus.cycle_count = r_cycle_count;

endmodule

// File: tb/tb_mc_sequencer.sv
// Randomized self-checking bench for mc_sequencer; the reference model expands
// each instruction description into its expected per-cycle trace.
module tb_mc_sequencer;
    localparam int unsigned WAIT_MAX = 8;
    localparam logic [5:0]  HALT_OP  = 6'b100100;

    logic        clk;
    logic        reset;
    int          n_checks;
    int          n_errors;
    logic [31:0] m_instr;
    logic [31:0] m_cycles;
    logic        m_bus_err;
    int          halt_len;

    mc_sequencer_if #(.OPCODE_W(6), .CNT_W(32)) bus ();

    mc_sequencer u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: inputs already driven; check outputs, then advance.
    task automatic cyc(input logic [2:0] es, input logic eu, input logic ew, input logic em);
        #1;
        chk("state",   32'(bus.state),   32'(es));
        chk("upd_pc",  32'(bus.upd_pc),  32'(eu));
        chk("wr_reg",  32'(bus.wr_reg),  32'(ew));
        chk("wr_mem",  32'(bus.wr_mem),  32'(em));
        chk("halted",  32'(bus.halted),  32'(es == 3'd5));
        chk("bus_err", 32'(bus.bus_err), 32'(m_bus_err));
        @(posedge clk);
        if (es != 3'd5) m_cycles++;
        #1;
    endtask

    task automatic halt_phase();
        logic [31:0] frozen;
        frozen = m_cycles;
        bus.resume = 1'b0;
        for (int i = 0; i < halt_len; i++) begin
            bus.step_req  = 1'($urandom);
            bus.mem_ready = 1'($urandom);
            cyc(3'd5, 1'b0, 1'b0, 1'b0);
        end
        chk("cycle_count_frozen", bus.cycle_count, frozen);
        bus.step_req = 1'b0;
        bus.resume   = 1'b1;
        cyc(3'd5, 1'b0, 1'b0, 1'b0);
        m_bus_err  = 1'b0;
        bus.resume = 1'b0;
    endtask

    // k: memory-wait cycles before ready (k > WAIT_MAX means timeout)
    task automatic run_instr(input logic [5:0] op, input logic up, input logic wr,
                             input logic wm, input logic rm, input int k, input logic stp);
        logic memop;
        logic eu;
        logic committed;
        memop         = rm | wm;
        eu            = up & (op != HALT_OP);
        committed     = 1'b0;
        bus.opcode    = op;
        bus.upd_pc_in = up;
        bus.wr_reg_in = wr;
        bus.wr_mem_in = wm;
        bus.rd_mem_in = rm;
        bus.step_mode = stp;
        bus.step_req  = 1'b0;
        bus.resume    = 1'b0;
        chk("instr_count", bus.instr_count, m_instr);
        chk("cycle_count", bus.cycle_count, m_cycles);
        bus.mem_ready = 1'($urandom);
        cyc(3'd0, 1'b0, 1'b0, 1'b0);
        bus.mem_ready = 1'($urandom);
        cyc(3'd1, 1'b0, 1'b0, 1'b0);
        if (!memop) begin
            bus.mem_ready = 1'($urandom);
            cyc(3'd2, eu, wr, wm);
            committed = 1'b1;
        end else if (k == 0) begin
            bus.mem_ready = 1'b1;
            cyc(3'd2, eu, wr, wm);
            committed = 1'b1;
        end else begin
            bus.mem_ready = 1'b0;
            cyc(3'd2, 1'b0, 1'b0, 1'b0);
            for (int i = 1; i <= int'(WAIT_MAX); i++) begin
                if (!committed) begin
                    if (i == k) begin
                        bus.mem_ready = 1'b1;
                        cyc(3'd3, eu, wr, wm);
                        committed = 1'b1;
                    end else begin
                        bus.mem_ready = 1'b0;
                        cyc(3'd3, 1'b0, 1'b0, 1'b0);
                    end
                end
            end
        end
        if (!committed) begin
            m_bus_err = 1'b1;
            halt_phase();
        end else begin
            m_instr++;
            if (op == HALT_OP) begin
                halt_phase();
            end else if (stp) begin
                for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
                    bus.step_req = 1'b0;
                    cyc(3'd4, 1'b0, 1'b0, 1'b0);
                end
                bus.step_req = 1'b1;
                cyc(3'd4, 1'b0, 1'b0, 1'b0);
                bus.step_req = 1'b0;
            end
        end
    endtask

    initial begin
        logic [5:0] op;
        logic       up, wr, wm, rm, stp;
        int         k;
        int         kind;
        n_checks  = 0;
        n_errors  = 0;
        m_instr   = '0;
        m_cycles  = '0;
        m_bus_err = 1'b0;
        halt_len  = 20;
        reset         = 1'b1;
        bus.opcode    = '0;
        bus.upd_pc_in = 1'b0;
        bus.wr_reg_in = 1'b0;
        bus.wr_mem_in = 1'b0;
        bus.rd_mem_in = 1'b0;
        bus.mem_ready = 1'b0;
        bus.step_mode = 1'b0;
        bus.step_req  = 1'b0;
        bus.resume    = 1'b0;
        repeat (3) @(posedge clk);
        bus.upd_pc_in = 1'b1;
        bus.wr_reg_in = 1'b1;
        #2;
        chk("rst_state",   32'(bus.state),   32'd0);
        chk("rst_halted",  32'(bus.halted),  32'd0);
        chk("rst_bus_err", 32'(bus.bus_err), 32'd0);
        chk("rst_instr",   bus.instr_count,  32'd0);
        chk("rst_cycles",  bus.cycle_count,  32'd0);
        chk("rst_wr_reg",  32'(bus.wr_reg),  32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Directed: two ALU ops, load with waits, timeout, halt op, single-step
        run_instr(6'h01, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        run_instr(6'h02, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        chk("two_instr_count", bus.instr_count, 32'd2);
        chk("two_cycle_count", bus.cycle_count, 32'd6);
        run_instr(6'h03, 1'b1, 1'b1, 1'b0, 1'b1, 2, 1'b0);
        run_instr(6'h04, 1'b1, 1'b1, 1'b0, 1'b1, WAIT_MAX + 1, 1'b0);
        run_instr(6'h05, 1'b1, 1'b0, 1'b1, 1'b0, WAIT_MAX, 1'b0);
        run_instr(HALT_OP, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 3; i++) run_instr(6'h06, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1);

        // Reset asserted mid-MEMWAIT acts before the next edge
        bus.opcode    = 6'h07;
        bus.rd_mem_in = 1'b1;
        bus.wr_mem_in = 1'b0;
        bus.step_mode = 1'b0;
        bus.mem_ready = 1'b0;
        cyc(3'd0, 1'b0, 1'b0, 1'b0);
        cyc(3'd1, 1'b0, 1'b0, 1'b0);
        cyc(3'd2, 1'b0, 1'b0, 1'b0);
        cyc(3'd3, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_state",  32'(bus.state), 32'd0);
        chk("async_rst_instr",  bus.instr_count, 32'd0);
        chk("async_rst_cycles", bus.cycle_count, 32'd0);
        bus.mem_ready = 1'b1;
        #1;
        chk("async_rst_wr_reg", 32'(bus.wr_reg), 32'd0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        m_instr   = '0;
        m_cycles  = '0;
        m_bus_err = 1'b0;

        // Randomized instruction stream
        for (int n = 0; n < 80; n++) begin
            kind = int'($urandom_range(0, 9));
            op   = 6'($urandom);
            if (op == HALT_OP) op = op ^ 6'h01;
            up   = 1'($urandom);
            wr   = 1'($urandom);
            wm   = 1'b0;
            rm   = 1'b0;
            k    = 0;
            stp  = ($urandom_range(0, 3) == 0);
            halt_len = int'($urandom_range(1, 25));
            if (kind >= 4 && kind <= 7) begin
                rm = 1'($urandom);
                wm = !rm;
                k  = int'($urandom_range(0, WAIT_MAX + 2));
            end else if (kind == 8) begin
                op = HALT_OP;
            end
            run_instr(op, up, wr, wm, rm, k, stp);
        end
        chk("final_instr",  bus.instr_count, m_instr);
        chk("final_cycles", bus.cycle_count, m_cycles);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
